// File: rtl/fault_event_tx_pkg.sv
// Shared types and constants for the fault event serializer.
// Event records pack the fault_pro and co_processor status into one byte.
package fault_event_tx_pkg;

  localparam int REC_W        = 8;
  localparam int REC_CODE_LSB = 5;
  localparam int REC_SUB_LSB  = 3;
  localparam int REC_Q_LSB    = 2;
  localparam int REC_Q1_LSB   = 0;
  localparam int DATA_BITS    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [2:0] code,
    input logic [1:0] sub,
    input logic       q,
    input logic [1:0] q1
  );
    return {code, sub, q, q1};
  endfunction

endpackage

// File: rtl/fault_event_tx_if.sv
// Status inputs, transmit enable and serial/status outputs of the serializer.
// The master side drives fault status; the slave side is the serializer.
interface fault_event_tx_if #(
  parameter int LVL_W = 3
);
  logic [2:0]       fault_code;
  logic [1:0]       fault_sub;
  logic             cop_q;
  logic [1:0]       cop_q1;
  logic             tx_en;
  logic             tx;
  logic             busy;
  logic             overflow;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output fault_code, fault_sub, cop_q, cop_q1, tx_en,
    input  tx, busy, overflow, fifo_level
  );

  modport slave (
    input  fault_code, fault_sub, cop_q, cop_q1, tx_en,
    output tx, busy, overflow, fifo_level
  );
endinterface

// File: rtl/fault_event_tx_fifo.sv
// Small synchronous FIFO for event records; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module fault_evt_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fault_event_tx.sv
// Captures new nonzero fault conditions as byte records, buffers them and
// sends each as a start/8-data-LSB-first/stop frame on the tx pin.
//
// state   | meaning
// S_IDLE  | line high, waiting for a buffered record and tx_en
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module fault_event_tx
  import fault_event_tx_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 4,
  parameter  int FIFO_DEPTH   = 4,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic              clk,
  input  logic              reset,
  fault_event_tx_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [REC_W-1:0] w_rec;
  logic             w_event;
  logic [REC_W-1:0] r_prev_rec;
  logic             r_overflow;

  logic [REC_W-1:0] w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [LVL_W-1:0] w_fifo_level;
  logic             w_pop;

  tx_state_e        r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [2:0]       r_bit,    w_bit_nxt;
  logic [REC_W-1:0] r_shift,  w_shift_nxt;
  logic             r_tx,     w_tx_nxt;
  logic             r_busy,   w_busy_nxt;

  assign w_rec   = pack_rec(bus.fault_code, bus.fault_sub, bus.cop_q, bus.cop_q1);
  assign w_event = (w_rec != r_prev_rec) && (bus.fault_code != 3'b000);

  fault_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_event),
    .i_pop   (w_pop),
    .i_wdata (w_rec),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  // A full FIFO drops the record only when no frame is starting on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_rec <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_rec <= w_rec;
      if (w_event && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_pop       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_fifo_empty && bus.tx_en) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_rdata;
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_LOAD;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = CNT_LOAD;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = CNT_LOAD;
          if (r_bit == 3'(DATA_BITS - 1)) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_LOAD;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.overflow   = r_overflow;
  assign bus.fifo_level = w_fifo_level;

endmodule

// File: tb/tb_fault_event_tx.sv
// Directed scenarios plus random fault traffic, checked every cycle against
// a queue-and-frame-position model of the serializer.
module tb_fault_event_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fault_event_tx_if #(.LVL_W(LVL_W)) bus ();

  fault_event_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_cur  = 8'h00;
  bit         m_ovf  = 1'b0;
  bit         m_active = 1'b0;
  int         m_pos  = 0;
  int         starts = 0;
  logic       prev_busy = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rec(input logic [7:0] r);
    bus.fault_code = r[7:5];
    bus.fault_sub  = r[4:3];
    bus.cop_q      = r[2];
    bus.cop_q1     = r[1:0];
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  task automatic step();
    logic [7:0] r;
    logic       en;
    logic       rst;
    r   = {bus.fault_code, bus.fault_sub, bus.cop_q, bus.cop_q1};
    en  = bus.tx_en;
    rst = reset;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_prev   = 8'h00;
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end else if (m_q.size() > 0 && en) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (r != m_prev && r[7:5] != 3'b000) begin
        if (m_q.size() < DEPTH) m_q.push_back(r);
        else m_ovf = 1'b1;
      end
      m_prev = r;
    end
    #1;
    if (bus.busy === 1'b1 && prev_busy !== 1'b1) starts++;
    prev_busy = bus.busy;
    check("tx",       {7'b0, bus.tx},       {7'b0, exp_tx()});
    check("busy",     {7'b0, bus.busy},     {7'b0, m_active});
    check("level",    {5'b0, bus.fifo_level}, 8'(m_q.size()));
    check("overflow", {7'b0, bus.overflow}, {7'b0, m_ovf});
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    logic [7:0] burst [5];
    logic [7:0] r;
    burst = '{8'h21, 8'h42, 8'h63, 8'h84, 8'hA5};

    // 1. reset and idle
    set_rec(8'h00);
    bus.tx_en = 1'b0;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    check("rst_tx",    {7'b0, bus.tx},   8'h01);
    check("rst_busy",  {7'b0, bus.busy}, 8'h00);
    check("rst_ovf",   {7'b0, bus.overflow}, 8'h00);
    check("rst_level", {5'b0, bus.fifo_level}, 8'h00);
    run(20);

    // 2/3. single event, held steady, then re-raised
    starts = 0;
    bus.tx_en = 1'b1;
    set_rec(8'hB5);
    step();
    check("cap_level", {5'b0, bus.fifo_level}, 8'h01);
    step();
    check("start_low", {7'b0, bus.tx}, 8'h00);
    run(100);
    check("steady_frames", 8'(starts), 8'd1);
    set_rec(8'h00);
    step();
    set_rec(8'hB5);
    run(50);
    check("refault_frames", 8'(starts), 8'd2);

    // 4. overflow with transmission held off
    bus.tx_en = 1'b0;
    foreach (burst[i]) begin
      set_rec(burst[i]);
      step();
    end
    check("burst_level", {5'b0, bus.fifo_level}, 8'd4);
    check("burst_ovf",   {7'b0, bus.overflow}, 8'h01);
    bus.tx_en = 1'b1;
    run(4 * (FRAME + 1) + 10);
    check("drain_level", {5'b0, bus.fifo_level}, 8'h00);

    // 5. full FIFO, pop and push on the same edge
    reset = 1'b1;
    set_rec(8'h00);
    step();
    reset = 1'b0;
    bus.tx_en = 1'b0;
    foreach (burst[i]) if (i < 4) begin
      set_rec(burst[i]);
      step();
    end
    check("full_level", {5'b0, bus.fifo_level}, 8'd4);
    bus.tx_en = 1'b1;
    set_rec(8'hE7);
    step();
    check("swap_ovf",   {7'b0, bus.overflow}, 8'h00);
    check("swap_level", {5'b0, bus.fifo_level}, 8'd4);
    check("swap_busy",  {7'b0, bus.busy}, 8'h01);
    run(5 * (FRAME + 1) + 10);

    // 6. reset during data bit 3
    set_rec(8'h5A);
    step();
    step();
    run(4 * CPB + 1);
    reset = 1'b1;
    set_rec(8'h00);
    step();
    reset = 1'b0;
    check("mid_rst_tx",    {7'b0, bus.tx},   8'h01);
    check("mid_rst_busy",  {7'b0, bus.busy}, 8'h00);
    check("mid_rst_level", {5'b0, bus.fifo_level}, 8'h00);
    starts = 0;
    run(60);
    check("no_resume", 8'(starts), 8'd0);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r[7:5] = 3'b000;
      set_rec(r);
      bus.tx_en = ($urandom_range(0, 4) != 0);
      reset = ($urandom_range(0, 60) == 0);
      step();
      reset = 1'b0;
      run($urandom_range(0, 25));
    end
    bus.tx_en = 1'b1;
    run(6 * (FRAME + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
